warp_ahb_arbiter: RTL and testbench
===================================

# warp_ahb_arbiter

Two-manager AHB5 arbiter that shares the single memory-side AHB port between the instruction cache (manager 0) and the data cache/LSU (manager 1). Ownership of the address phase is granted per burst and released only when the owner returns to IDLE. Data-phase responses are routed back to the manager that issued the transfer. The block sits between the two cache fill/writeback engines and the system interconnect, and is pure bus plumbing plus a small grant FSM.

## Interface
Parameters:
- AW, 64, address width
- DW, 64, data width (HWSTRB is DW/8)

Ports (k = 0 icache, k = 1 dcache; each line covers both managers):
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_mk_haddr  in  AW  manager k address
- i_mk_htrans  in  2  manager k transfer type
- i_mk_hburst / i_mk_hsize / i_mk_hprot  in  3/3/4  manager k control
- i_mk_hwrite, i_mk_hmastlock  in  1  manager k control
- i_mk_hwdata / i_mk_hwstrb  in  DW/DW/8  manager k write data
- o_mk_hrdata  out  DW  read data (broadcast of i_s_hrdata)
- o_mk_hready  out  1  manager k transfer done / address accepted
- o_mk_hresp  out  1  manager k response
- o_s_haddr, o_s_htrans, o_s_hburst, o_s_hsize, o_s_hprot, o_s_hwrite, o_s_hmastlock, o_s_hwdata, o_s_hwstrb  out  as above  subordinate-side request
- i_s_hrdata  in  DW; i_s_hready  in  1; i_s_hresp  in  1  subordinate response
- o_grant  out  2  one-hot current address-phase owner (debug/perf)

## Operation
- A request is `i_mk_htrans == NONSEQ`.
- FSM states: ARB_IDLE, ARB_M0, ARB_M1. State is registered, and o_s_* is a combinational mux of the owner's inputs.
- ARB_IDLE: o_s_htrans = IDLE and all other o_s_* = 0.
  - If any manager requests, go to ARB_Mk (see Configuration for tie-break).
  - The requester sees o_mk_hready = 0 for this cycle and holds its NONSEQ.
- ARB_Mk: all o_s_* follow manager k.
  - Leave when i_s_hready = 1, i_mk_htrans == IDLE and i_mk_hmastlock = 0.
  - On leaving, go directly to ARB_Mj if the other manager j is requesting, else go to ARB_IDLE.
  - BUSY and SEQ never release ownership.
- Data-phase owner register:
  - When i_s_hready = 1: d_owner <= current owner, and d_valid <= o_s_htrans[1].
  - When i_s_hready = 0: both hold.
- o_mk_hready:
  - = i_s_hready if state == ARB_Mk, or (d_valid and d_owner == k).
  - Else 1 if i_mk_htrans == IDLE (zero-wait IDLE response).
  - Else 0.
- o_mk_hresp = i_s_hresp if d_valid and d_owner == k, else OKAY (0).
- No write data is dropped: o_s_hwdata/hwstrb are muxed by d_owner, not by the address owner.
- Reset mid-burst: the FSM returns to ARB_IDLE and d_valid is cleared. Managers are reset by the same i_rst, so no recovery handshake is needed.

## Timing
- Reset values:
  - state = ARB_IDLE, d_valid = 0, d_owner = 0, round-robin pointer = 0, o_grant = 0.
  - o_s_htrans = IDLE and every other o_s_* = 0.
  - o_mk_hresp = 0.
  - o_mk_hready = 1 iff i_mk_htrans == IDLE.
- Grant latency: 1 cycle from the first NONSEQ to its appearance on o_s_htrans when the bus is idle. Handover at release costs 0 extra cycles.
- Back-to-back handover: the last data phase of the old owner overlaps the first address phase of the new owner.
- Simultaneous requests in ARB_IDLE are resolved per Configuration; the loser waits until the winner's release.

## Configuration
- WARP_ARB_RR_EN defined: round-robin. On a tie, the manager other than the last granted wins. The pointer updates on every entry into ARB_Mk.
- WARP_ARB_RR_EN undefined: fixed priority; the dcache (manager 1) always wins ties and the pointer is not instantiated.

## Structure
- warp_ahb_pkg holds:
  - HTRANS_*, HBURST_*, HSIZE_*, HRESP_* constants
  - ARB_* state encodings
- One sub-module, warp_ahb_req_mux, performs the select-driven mux of one manager's request bundle onto o_s_*. It is instantiated for the address-phase signals (select = owner) and the write-data signals (select = d_owner).

## Test plan
- Single icache WRAP8 read, subordinate zero-wait → NONSEQ appears 1 cycle after request, 8 beats complete, FSM returns to ARB_IDLE, o_m1_hready stays 1 throughout.
- Both managers assert NONSEQ in the same cycle, fixed priority → dcache granted first, icache o_m0_hready = 0 until dcache drives IDLE, then icache granted with 0 extra cycles.
- Same stimulus with WARP_ARB_RR_EN, repeated 4 times → grants alternate m1, m0, m1, m0.
- Subordinate inserts 3 wait states on beat 5 → o_s_haddr/htrans stable; only the owner's hready is low for 3 cycles.
- dcache write whose last beat overlaps an icache NONSEQ → o_s_hwdata carries dcache data during the icache address phase.
- i_s_hresp = ERROR on a dcache beat → only o_m1_hresp = 1. Then assert i_rst mid-burst → o_s_htrans = IDLE and o_grant = 0 immediately (asynchronously).

Source files
------------

// File: rtl/warp_ahb_pkg.sv
// Shared AHB5 encodings and arbiter state type for the warp memory-side arbiter.
package warp_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/warp_ahb_req_mux.sv
// Two-way select of one manager request bundle; forces all-zero (IDLE) when disabled.
module warp_ahb_req_mux #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic         sel,
  input  logic [W-1:0] req0,
  input  logic [W-1:0] req1,
  output logic [W-1:0] out
);
  assign out = !en ? '0 : (sel ? req1 : req0);
endmodule

// File: rtl/warp_ahb_arbiter.sv
// Two-manager AHB5 arbiter (icache = m0, dcache = m1) onto one subordinate port.
// Define WARP_ARB_RR_EN for round-robin tie-break; default is fixed dcache priority.
module warp_ahb_arbiter import warp_ahb_pkg::*; #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_m0_haddr,
  input  logic [1:0]      i_m0_htrans,
  input  logic [2:0]      i_m0_hburst,
  input  logic [2:0]      i_m0_hsize,
  input  logic [3:0]      i_m0_hprot,
  input  logic            i_m0_hwrite,
  input  logic            i_m0_hmastlock,
  input  logic [DW-1:0]   i_m0_hwdata,
  input  logic [DW/8-1:0] i_m0_hwstrb,
  output logic [DW-1:0]   o_m0_hrdata,
  output logic            o_m0_hready,
  output logic            o_m0_hresp,
  input  logic [AW-1:0]   i_m1_haddr,
  input  logic [1:0]      i_m1_htrans,
  input  logic [2:0]      i_m1_hburst,
  input  logic [2:0]      i_m1_hsize,
  input  logic [3:0]      i_m1_hprot,
  input  logic            i_m1_hwrite,
  input  logic            i_m1_hmastlock,
  input  logic [DW-1:0]   i_m1_hwdata,
  input  logic [DW/8-1:0] i_m1_hwstrb,
  output logic [DW-1:0]   o_m1_hrdata,
  output logic            o_m1_hready,
  output logic            o_m1_hresp,
  output logic [AW-1:0]   o_s_haddr,
  output logic [1:0]      o_s_htrans,
  output logic [2:0]      o_s_hburst,
  output logic [2:0]      o_s_hsize,
  output logic [3:0]      o_s_hprot,
  output logic            o_s_hwrite,
  output logic            o_s_hmastlock,
  output logic [DW-1:0]   o_s_hwdata,
  output logic [DW/8-1:0] o_s_hwstrb,
  input  logic [DW-1:0]   i_s_hrdata,
  input  logic            i_s_hready,
  input  logic            i_s_hresp,
  output logic [1:0]      o_grant
);
  localparam int AREQ_W = AW + 2 + 3 + 3 + 4 + 1 + 1;
  localparam int WREQ_W = DW + DW/8;

  arb_state_e state, state_nxt;
  logic       req0, req1, rel0, rel1, tie_m1;
  logic       owner, d_owner, d_valid;

  assign req0 = (i_m0_htrans == HTRANS_NONSEQ);
  assign req1 = (i_m1_htrans == HTRANS_NONSEQ);
  assign rel0 = i_s_hready && (i_m0_htrans == HTRANS_IDLE) && !i_m0_hmastlock;
  assign rel1 = i_s_hready && (i_m1_htrans == HTRANS_IDLE) && !i_m1_hmastlock;

`ifdef WARP_ARB_RR_EN
  logic rr_last;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                         rr_last <= 1'b0;
    else if (state_nxt == ARB_M0 && state != ARB_M0)   rr_last <= 1'b0;
    else if (state_nxt == ARB_M1 && state != ARB_M1)   rr_last <= 1'b1;
  end
  assign tie_m1 = !rr_last;
`else
  assign tie_m1 = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (req0 && req1) state_nxt = tie_m1 ? ARB_M1 : ARB_M0;
        else if (req1)    state_nxt = ARB_M1;
        else if (req0)    state_nxt = ARB_M0;
      end
      ARB_M0:  if (rel0) state_nxt = req1 ? ARB_M1 : ARB_IDLE;
      ARB_M1:  if (rel1) state_nxt = req0 ? ARB_M0 : ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign owner   = (state == ARB_M1);
  assign o_grant = {state == ARB_M1, state == ARB_M0};

  // Data phase belongs to whoever owned the address phase when it was accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_valid <= 1'b0;
      d_owner <= 1'b0;
    end else if (i_s_hready) begin
      d_valid <= o_s_htrans[1];
      d_owner <= owner;
    end
  end

  logic [AREQ_W-1:0] areq0, areq1, s_areq;
  logic [WREQ_W-1:0] wreq0, wreq1, s_wreq;

  assign areq0 = {i_m0_haddr, i_m0_htrans, i_m0_hburst, i_m0_hsize, i_m0_hprot,
                  i_m0_hwrite, i_m0_hmastlock};
  assign areq1 = {i_m1_haddr, i_m1_htrans, i_m1_hburst, i_m1_hsize, i_m1_hprot,
                  i_m1_hwrite, i_m1_hmastlock};
  assign wreq0 = {i_m0_hwdata, i_m0_hwstrb};
  assign wreq1 = {i_m1_hwdata, i_m1_hwstrb};

  warp_ahb_req_mux #(.W(AREQ_W)) u_amux (
    .en(state != ARB_IDLE), .sel(owner), .req0(areq0), .req1(areq1), .out(s_areq)
  );
  warp_ahb_req_mux #(.W(WREQ_W)) u_wmux (
    .en(d_valid), .sel(d_owner), .req0(wreq0), .req1(wreq1), .out(s_wreq)
  );

  assign {o_s_haddr, o_s_htrans, o_s_hburst, o_s_hsize, o_s_hprot,
          o_s_hwrite, o_s_hmastlock} = s_areq;
  assign {o_s_hwdata, o_s_hwstrb} = s_wreq;

  assign o_m0_hrdata = i_s_hrdata;
  assign o_m1_hrdata = i_s_hrdata;

  // Non-owners see zero-wait IDLE responses; a waiting NONSEQ is stalled.
  assign o_m0_hready = (state == ARB_M0 || (d_valid && !d_owner)) ? i_s_hready
                                                                   : (i_m0_htrans == HTRANS_IDLE);
  assign o_m1_hready = (state == ARB_M1 || (d_valid &&  d_owner)) ? i_s_hready
                                                                   : (i_m1_htrans == HTRANS_IDLE);
  assign o_m0_hresp  = (d_valid && !d_owner) ? i_s_hresp : HRESP_OKAY;
  assign o_m1_hresp  = (d_valid &&  d_owner) ? i_s_hresp : HRESP_OKAY;
endmodule

// File: tb/tb_warp_ahb_arbiter.sv
// Randomized bench: two burst-driving managers and a random-wait subordinate, checked
// every cycle against an ownership/data-phase reference model.
module tb_warp_ahb_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]   m_haddr [2];
  logic [1:0]      m_htrans[2];
  logic [2:0]      m_hburst[2];
  logic [2:0]      m_hsize [2];
  logic [3:0]      m_hprot [2];
  logic            m_hwrite[2];
  logic            m_hlock [2];
  logic [DW-1:0]   m_hwdata[2];
  logic [DW/8-1:0] m_hwstrb[2];
  logic [DW-1:0]   m_hrdata[2];
  logic            m_hready[2];
  logic            m_hresp [2];

  logic [AW-1:0]   s_haddr;
  logic [1:0]      s_htrans;
  logic [2:0]      s_hburst, s_hsize;
  logic [3:0]      s_hprot;
  logic            s_hwrite, s_hlock;
  logic [DW-1:0]   s_hwdata, s_hrdata;
  logic [DW/8-1:0] s_hwstrb;
  logic            s_hready, s_hresp;
  logic [1:0]      grant;

  warp_ahb_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_haddr(m_haddr[0]), .i_m0_htrans(m_htrans[0]), .i_m0_hburst(m_hburst[0]),
    .i_m0_hsize(m_hsize[0]), .i_m0_hprot(m_hprot[0]), .i_m0_hwrite(m_hwrite[0]),
    .i_m0_hmastlock(m_hlock[0]), .i_m0_hwdata(m_hwdata[0]), .i_m0_hwstrb(m_hwstrb[0]),
    .o_m0_hrdata(m_hrdata[0]), .o_m0_hready(m_hready[0]), .o_m0_hresp(m_hresp[0]),
    .i_m1_haddr(m_haddr[1]), .i_m1_htrans(m_htrans[1]), .i_m1_hburst(m_hburst[1]),
    .i_m1_hsize(m_hsize[1]), .i_m1_hprot(m_hprot[1]), .i_m1_hwrite(m_hwrite[1]),
    .i_m1_hmastlock(m_hlock[1]), .i_m1_hwdata(m_hwdata[1]), .i_m1_hwstrb(m_hwstrb[1]),
    .o_m1_hrdata(m_hrdata[1]), .o_m1_hready(m_hready[1]), .o_m1_hresp(m_hresp[1]),
    .o_s_haddr(s_haddr), .o_s_htrans(s_htrans), .o_s_hburst(s_hburst),
    .o_s_hsize(s_hsize), .o_s_hprot(s_hprot), .o_s_hwrite(s_hwrite),
    .o_s_hmastlock(s_hlock), .o_s_hwdata(s_hwdata), .o_s_hwstrb(s_hwstrb),
    .i_s_hrdata(s_hrdata), .i_s_hready(s_hready), .i_s_hresp(s_hresp),
    .o_grant(grant)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the address bus (-1 = nobody), the last manager granted,
  // and the in-flight data phase (valid + manager).
  int own = -1;
  int last = 0;
  bit dp_v = 1'b0;
  int dp_m = 0;
  int n_grant[2];

  function automatic int tie_winner();
`ifdef WARP_ARB_RR_EN
    return 1 - last;
`else
    return 1;
`endif
  endfunction

  task automatic model_edge();
    bit req[2];
    int nxt;
    for (int k = 0; k < 2; k++) req[k] = (m_htrans[k] == 2'b10);
    if (s_hready) begin
      dp_v = (own >= 0) && m_htrans[(own < 0) ? 0 : own][1];
      dp_m = (own < 0) ? 0 : own;
    end
    nxt = own;
    if (own < 0) begin
      if (req[0] && req[1]) nxt = tie_winner();
      else if (req[1])      nxt = 1;
      else if (req[0])      nxt = 0;
    end else if (s_hready && m_htrans[own] == 2'b00 && !m_hlock[own]) begin
      nxt = req[1-own] ? 1 - own : -1;
    end
    if (nxt >= 0 && nxt != own) begin
      last = nxt;
      n_grant[nxt]++;
    end
    own = nxt;
  endtask

  task automatic check_outputs();
    int  o = (own < 0) ? 0 : own;
    bit  en = (own >= 0);
    bit  busy;
    chk("htrans", 64'(s_htrans), en ? 64'(m_htrans[o]) : 64'd0);
    chk("haddr",  s_haddr,       en ? m_haddr[o] : 64'd0);
    chk("hctrl",  64'({s_hburst, s_hsize, s_hprot, s_hwrite, s_hlock}),
        en ? 64'({m_hburst[o], m_hsize[o], m_hprot[o], m_hwrite[o], m_hlock[o]}) : 64'd0);
    chk("grant",  64'(grant), en ? 64'(own + 1) : 64'd0);
    chk("hwdata", s_hwdata, dp_v ? m_hwdata[dp_m] : 64'd0);
    chk("hwstrb", 64'(s_hwstrb), dp_v ? 64'(m_hwstrb[dp_m]) : 64'd0);
    for (int k = 0; k < 2; k++) begin
      busy = (own == k) || (dp_v && dp_m == k);
      chk($sformatf("hready%0d", k), 64'(m_hready[k]),
          busy ? 64'(s_hready) : 64'(m_htrans[k] == 2'b00));
      chk($sformatf("hresp%0d", k), 64'(m_hresp[k]),
          (dp_v && dp_m == k) ? 64'(s_hresp) : 64'd0);
      chk($sformatf("hrdata%0d", k), m_hrdata[k], s_hrdata);
    end
  endtask

  // Manager behaviour: bursts of 1..8 beats with random BUSY, optional locked
  // sequences that keep HMASTLOCK through a few trailing IDLE cycles.
  int left[2];
  int lockcnt[2];
  bit blk[2];
  bit samp_rdy[2];

  task automatic mgr_reset(input int k);
    m_haddr[k] = '0; m_htrans[k] = 2'b00; m_hburst[k] = '0; m_hsize[k] = '0;
    m_hprot[k] = '0; m_hwrite[k] = 1'b0; m_hlock[k] = 1'b0;
    m_hwdata[k] = '0; m_hwstrb[k] = '0;
    left[k] = 0; lockcnt[k] = 0; blk[k] = 1'b0; samp_rdy[k] = 1'b1;
  endtask

  task automatic mgr_edge(input int k);
    m_hwdata[k] = {$urandom, $urandom};
    m_hwstrb[k] = 8'($urandom);
    if (!samp_rdy[k]) return;
    case (m_htrans[k])
      2'b10, 2'b11: begin
        left[k]--;
        m_haddr[k] = m_haddr[k] + 64'd8;
        if (left[k] == 0) begin
          m_htrans[k] = 2'b00;
          lockcnt[k]  = blk[k] ? int'($urandom_range(0, 2)) : 0;
          m_hlock[k]  = (lockcnt[k] > 0);
        end else begin
          m_htrans[k] = ($urandom % 6 == 0) ? 2'b01 : 2'b11;
        end
      end
      2'b01: m_htrans[k] = ($urandom % 3 == 0) ? 2'b01 : 2'b11;
      default: begin
        if (lockcnt[k] > 0) begin
          lockcnt[k]--;
          if (lockcnt[k] == 0) m_hlock[k] = 1'b0;
        end else if ($urandom % 4 == 0) begin
          left[k]     = int'($urandom_range(1, 8));
          m_htrans[k] = 2'b10;
          m_haddr[k]  = {32'h0, $urandom & 32'hFFFF_FFC0};
          m_hburst[k] = (left[k] == 8) ? 3'b100 : 3'b001;
          m_hsize[k]  = 3'b011;
          m_hprot[k]  = 4'($urandom);
          m_hwrite[k] = 1'($urandom);
          blk[k]      = ($urandom % 5 == 0);
          m_hlock[k]  = blk[k];
        end
      end
    endcase
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mgr_reset(k);
      n_grant[k] = 0;
    end
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;

    // Reset state, with icache already presenting a NONSEQ.
    repeat (2) @(posedge clk);
    #1 m_htrans[0] = 2'b10;
    @(negedge clk);
    chk("rst_htrans", 64'(s_htrans), 64'd0);
    chk("rst_grant",  64'(grant), 64'd0);
    chk("rst_haddr",  s_haddr, 64'd0);
    chk("rst_hwdata", s_hwdata, 64'd0);
    chk("rst_hready0", 64'(m_hready[0]), 64'd0);
    chk("rst_hready1", 64'(m_hready[1]), 64'd1);
    chk("rst_hresp0", 64'(m_hresp[0]), 64'd0);
    chk("rst_hresp1", 64'(m_hresp[1]), 64'd0);
    m_htrans[0] = 2'b00;
    #2 rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_edge();
      for (int k = 0; k < 2; k++) mgr_edge(k);
      s_hready = ($urandom % 10) < 7;
      s_hresp  = ($urandom % 12) == 0;
      s_hrdata = {$urandom, $urandom};
      @(negedge clk);
      check_outputs();
      for (int k = 0; k < 2; k++) samp_rdy[k] = m_hready[k];

      // Asynchronous reset mid-traffic: bus must drop to IDLE without a clock edge.
      if (cyc == NCYC / 2) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_htrans", 64'(s_htrans), 64'd0);
        chk("arst_grant",  64'(grant), 64'd0);
        chk("arst_hresp",  64'({m_hresp[0], m_hresp[1]}), 64'd0);
        own = -1; last = 0; dp_v = 1'b0; dp_m = 0;
        for (int k = 0; k < 2; k++) mgr_reset(k);
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    if (n_grant[0] == 0 || n_grant[1] == 0) begin
      failures++;
      $display("FAIL coverage grants m0=%0d m1=%0d want both >0", n_grant[0], n_grant[1]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
